// File: rtl/io_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : io_uart_tx
//  Purpose  : Bus-mapped UART transmitter with a 4-entry byte FIFO.
//             Register window at BASE_ADDR: +0 TXDATA (W), +1 STATUS (R),
//             +2 CTRL (R/W, bit0 = transmit enable).
//             Frames are 8N1, LSB first, BAUD_DIV clocks per bit.
//  Options  : define UART_TX_IRQ_EN to build the end-of-transmission
//             interrupt (BUS_INTERRUPT_RAISE / BUS_INTERRUPT_ACK handshake).
//             Without it BUS_INTERRUPT_RAISE is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module io_uart_tx #(
   parameter logic [7:0] BASE_ADDR = 8'hE0,
   parameter int         BAUD_DIV  = 868
) (
   input  logic       CLK,
   input  logic       RESET,
   inout  wire  [7:0] BUS_DATA,
   input  logic [7:0] BUS_ADDR,
   input  logic       BUS_WE,
   output logic       UART_TX,
   output logic       BUS_INTERRUPT_RAISE,
   input  logic       BUS_INTERRUPT_ACK
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam logic [7:0] c_addr_txdata = BASE_ADDR;
   localparam logic [7:0] c_addr_status = BASE_ADDR + 8'd1;
   localparam logic [7:0] c_addr_ctrl   = BASE_ADDR + 8'd2;

   localparam int                  c_baud_w    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(BAUD_DIV - 1);
   localparam logic [c_baud_w-1:0] c_baud_one  = c_baud_w'(1);

   localparam logic [2:0] c_fifo_depth = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // Registers and next-state values
   // ------------------------------------------------------------------------
   state_t              state_q, state_d;
   logic [c_baud_w-1:0] baud_q,  baud_d;
   logic [2:0]          bit_q,   bit_d;
   logic [7:0]          shift_q, shift_d;
   logic                tx_q,    tx_d;

   logic [7:0]          fifo_mem_q [4];
   logic [1:0]          wr_ptr_q,  wr_ptr_d;
   logic [1:0]          rd_ptr_q,  rd_ptr_d;
   logic [2:0]          count_q,   count_d;

   logic                ctrl_en_q, ctrl_en_d;
   logic                ovf_q,     ovf_d;
   logic                rd_en_q,   rd_en_d;
   logic [7:0]          rd_data_q, rd_data_d;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic       w_wr_txdata;
   logic       w_wr_ctrl;
   logic       w_rd_status;
   logic       w_rd_ctrl;
   logic       w_fifo_empty;
   logic       w_fifo_full;
   logic [7:0] w_fifo_head;
   logic       w_bit_end;
   logic       w_busy;
   logic [7:0] w_status;
   logic       w_pop;
   logic       w_push_ok;
   logic       w_overflow;
   logic       w_frame_done;

   assign w_wr_txdata  = BUS_WE  && (BUS_ADDR == c_addr_txdata);
   assign w_wr_ctrl    = BUS_WE  && (BUS_ADDR == c_addr_ctrl);
   assign w_rd_status  = !BUS_WE && (BUS_ADDR == c_addr_status);
   assign w_rd_ctrl    = !BUS_WE && (BUS_ADDR == c_addr_ctrl);

   assign w_fifo_empty = (count_q == 3'd0);
   assign w_fifo_full  = (count_q == c_fifo_depth);
   assign w_fifo_head  = fifo_mem_q[rd_ptr_q];

   assign w_bit_end    = (baud_q == c_baud_last);

   // Queued bytes count as busy even before the transmitter picks them up.
   assign w_busy       = !w_fifo_empty || (state_q != ST_IDLE);
   assign w_status     = {5'b0, ovf_q, w_fifo_full, w_busy};

   // ------------------------------------------------------------------------
   // Transmit FSM next-state, baud/bit counters, shifter and line value
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      baud_d       = baud_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      tx_d         = tx_q;
      w_pop        = 1'b0;
      w_frame_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            baud_d = '0;
            tx_d   = 1'b1;
            if (ctrl_en_q && !w_fifo_empty) begin
               w_pop   = 1'b1;
               shift_d = w_fifo_head;
               tx_d    = 1'b0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (w_bit_end) begin
               baud_d  = '0;
               tx_d    = shift_q[0];
               state_d = ST_DATA;
            end else begin
               baud_d  = baud_q + c_baud_one;
            end
         end
         ST_DATA: begin
            if (w_bit_end) begin
               baud_d  = '0;
               // 3-bit counter naturally wraps 7 -> 0 as the last bit ends.
               bit_d   = bit_q + 3'd1;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = ST_STOP;
               end else begin
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d  = baud_q + c_baud_one;
            end
         end
         ST_STOP: begin
            if (w_bit_end) begin
               baud_d       = '0;
               w_frame_done = 1'b1;
               // Chain straight into the next start bit when more data waits.
               if (ctrl_en_q && !w_fifo_empty) begin
                  w_pop   = 1'b1;
                  shift_d = w_fifo_head;
                  tx_d    = 1'b0;
                  state_d = ST_START;
               end else begin
                  tx_d    = 1'b1;
                  state_d = ST_IDLE;
               end
            end else begin
               baud_d = baud_q + c_baud_one;
            end
         end
         default: begin
            baud_d  = '0;
            tx_d    = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // FIFO bookkeeping, control register, overflow flag and read capture
   // ------------------------------------------------------------------------
   // A push into a full FIFO only succeeds when the transmitter pops in the
   // same cycle; otherwise the byte is dropped and overflow latches.
   assign w_push_ok  = w_wr_txdata && (!w_fifo_full || w_pop);
   assign w_overflow = w_wr_txdata && w_fifo_full && !w_pop;

   always_comb begin
      wr_ptr_d  = wr_ptr_q + {1'b0, w_push_ok};
      rd_ptr_d  = rd_ptr_q + {1'b0, w_pop};
      count_d   = count_q + {2'b0, w_push_ok} - {2'b0, w_pop};

      ctrl_en_d = w_wr_ctrl ? BUS_DATA[0] : ctrl_en_q;

      ovf_d     = ovf_q;
      if (w_rd_status) begin
         ovf_d = 1'b0;
      end else if (w_overflow) begin
         ovf_d = 1'b1;
      end

      rd_en_d   = w_rd_status || w_rd_ctrl;
      rd_data_d = 8'h00;
      if (w_rd_status) begin
         rd_data_d = w_status;
      end else if (w_rd_ctrl) begin
         rd_data_d = {7'b0, ctrl_en_q};
      end
   end

   // State and control registers; reset wins over any bus activity.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= ST_IDLE;
         baud_q    <= '0;
         bit_q     <= 3'd0;
         shift_q   <= 8'h00;
         tx_q      <= 1'b1;
         wr_ptr_q  <= 2'd0;
         rd_ptr_q  <= 2'd0;
         count_q   <= 3'd0;
         ctrl_en_q <= 1'b0;
         ovf_q     <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_data_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ctrl_en_q <= ctrl_en_d;
         ovf_q     <= ovf_d;
         rd_en_q   <= rd_en_d;
         rd_data_q <= rd_data_d;
      end
   end

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge CLK) begin
      if (!RESET && w_push_ok) begin
         fifo_mem_q[wr_ptr_q] <= BUS_DATA;
      end
   end

   assign UART_TX  = tx_q;
   assign BUS_DATA = rd_en_q ? rd_data_q : 8'hzz;

   // ------------------------------------------------------------------------
   // End-of-transmission interrupt
   // ------------------------------------------------------------------------
`ifdef UART_TX_IRQ_EN
   logic irq_q, irq_d;

   // Raise when the last queued frame finishes; a new raise beats an ACK.
   always_comb begin
      irq_d = irq_q;
      if (w_frame_done && w_fifo_empty) begin
         irq_d = 1'b1;
      end else if (BUS_INTERRUPT_ACK) begin
         irq_d = 1'b0;
      end
   end

   // Interrupt request register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign BUS_INTERRUPT_RAISE = irq_q;
`else
   logic w_unused_irq;
   assign w_unused_irq        = BUS_INTERRUPT_ACK | w_frame_done;
   assign BUS_INTERRUPT_RAISE = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_io_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_io_uart_tx
//  Purpose  : Self-checking bench for io_uart_tx with BAUD_DIV = 4.
//             The bus carries pull-ups, so an undriven bus reads 8'hFF.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_io_uart_tx;

   localparam int         c_baud  = 4;
   localparam logic [7:0] c_tx    = 8'hE0;
   localparam logic [7:0] c_st    = 8'hE1;
   localparam logic [7:0] c_ctrl  = 8'hE2;
   localparam logic [7:0] c_hiz   = 8'hFF;

   localparam int OP_WR   = 0;
   localparam int OP_RD   = 1;
   localparam int OP_IDLE = 2;

   typedef struct {
      int         op;
      logic [7:0] addr;
      logic [7:0] data;
      string      name;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] bus_addr = 8'h00;
   logic       bus_we = 1'b0;
   logic       tb_drv = 1'b0;
   logic [7:0] tb_wdata = 8'h00;
   logic       irq_ack = 1'b0;
   logic       uart_tx;
   logic       irq_raise;
   wire  [7:0] bus_data;

   int n_total = 0;
   int n_pass  = 0;

   assign bus_data = tb_drv ? tb_wdata : 8'hzz;

   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (bus_data[g]);
   end

   io_uart_tx #(
      .BASE_ADDR (8'hE0),
      .BAUD_DIV  (c_baud)
   ) dut (
      .CLK                 (clk),
      .RESET               (rst),
      .BUS_DATA            (bus_data),
      .BUS_ADDR            (bus_addr),
      .BUS_WE              (bus_we),
      .UART_TX             (uart_tx),
      .BUS_INTERRUPT_RAISE (irq_raise),
      .BUS_INTERRUPT_ACK   (irq_ack)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
      n_total++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %02h, expected %02h", name, act, exp_v);
   endtask

   task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
      @(negedge clk);
      bus_addr = addr; bus_we = 1'b1; tb_wdata = data; tb_drv = 1'b1;
      @(negedge clk);
      bus_addr = 8'h00; bus_we = 1'b0; tb_drv = 1'b0;
   endtask

   // Bus must stay released until the capture edge, then show the register.
   task automatic bus_read(input string name, input logic [7:0] addr, input logic [7:0] exp_v);
      @(negedge clk);
      bus_addr = addr; bus_we = 1'b0;
      #1;
      chk({name, "_pre"}, bus_data, c_hiz);
      @(negedge clk);
      chk(name, bus_data, exp_v);
      bus_addr = 8'h00;
   endtask

   // Captures one 40-cycle frame; the start bit must appear within max_wait cycles.
   task automatic check_frame(input string name, input logic [7:0] b, input int max_wait);
      logic [39:0] cap;
      logic [39:0] e_bits;
      int w;
      for (int i = 0; i < 40; i++)
         e_bits[39-i] = (i < 4) ? 1'b0 : (i < 36) ? b[(i-4)/4] : 1'b1;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (uart_tx !== 1'b0 && w < max_wait);
      n_total++;
      if (uart_tx !== 1'b0) begin
         $display("FAIL %s_start: line still %0b after %0d cycles, expected 0", name, uart_tx, w);
         return;
      end
      n_pass++;
      cap = '0;
      cap[39] = uart_tx;
      for (int i = 1; i < 40; i++) begin
         @(negedge clk);
         cap[39-i] = uart_tx;
      end
      n_total++;
      if (cap === e_bits) n_pass++;
      else $display("FAIL %s: line %010h, expected %010h", name, cap, e_bits);
   endtask

   initial begin
      vec_t vecs[14];
      int   cnt;

      vecs[0]  = '{OP_RD,   c_ctrl, 8'h00, "rst_ctrl"};
      vecs[1]  = '{OP_RD,   c_st,   8'h00, "rst_status"};
      vecs[2]  = '{OP_IDLE, 8'h00,  c_hiz, "rst_status_release"};
      vecs[3]  = '{OP_RD,   c_tx,   c_hiz, "txdata_not_readable"};
      vecs[4]  = '{OP_RD,   8'hE3,  c_hiz, "unmapped_not_readable"};
      vecs[5]  = '{OP_WR,   c_ctrl, 8'h01, "wr_ctrl_1"};
      vecs[6]  = '{OP_RD,   c_ctrl, 8'h01, "ctrl_read"};
      vecs[7]  = '{OP_IDLE, 8'h00,  c_hiz, "ctrl_read_release"};
      vecs[8]  = '{OP_WR,   c_ctrl, 8'hFE, "wr_ctrl_fe"};
      vecs[9]  = '{OP_RD,   c_ctrl, 8'h00, "ctrl_bit0_only"};
      vecs[10] = '{OP_WR,   c_ctrl, 8'h01, "wr_ctrl_1b"};
      vecs[11] = '{OP_RD,   c_ctrl, 8'h01, "ctrl_reenabled"};
      vecs[12] = '{OP_IDLE, 8'h00,  c_hiz, "ctrl_release2"};
      vecs[13] = '{OP_RD,   c_st,   8'h00, "status_idle_enabled"};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_uart_tx", {7'b0, uart_tx}, 8'h01);
      chk("rst_irq", {7'b0, irq_raise}, 8'h00);
      chk("rst_bus_z", bus_data, c_hiz);
      rst = 1'b0;

      // Register map vectors
      for (int i = 0; i < 14; i++) begin
         case (vecs[i].op)
            OP_WR: bus_write(vecs[i].addr, vecs[i].data);
            OP_RD: bus_read(vecs[i].name, vecs[i].addr, vecs[i].data);
            default: begin
               @(negedge clk);
               chk(vecs[i].name, bus_data, vecs[i].data);
            end
         endcase
      end

      // Single frame A5 with STATUS busy during and idle after
      bus_write(c_tx, 8'hA5);
      fork
         check_frame("frame_A5", 8'hA5, 1);
         begin
            repeat (12) @(negedge clk);
            bus_read("status_busy", c_st, 8'h01);
         end
      join
      bus_read("status_after_frame", c_st, 8'h00);

      // Overflow: five pushes into a disabled transmitter. A full FIFO also
      // holds queued data, so busy is set alongside full.
      bus_write(c_ctrl, 8'h00);
      for (int b = 1; b <= 5; b++) bus_write(c_tx, 8'(b));
      bus_read("status_overflow", c_st, 8'h07);
      bus_read("status_ovf_cleared", c_st, 8'h03);
      bus_write(c_ctrl, 8'h01);
      check_frame("frame_01", 8'h01, 1);
      check_frame("frame_02", 8'h02, 1);
      check_frame("frame_03", 8'h03, 1);
      check_frame("frame_04", 8'h04, 1);
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) cnt++;
      end
      chk("no_dropped_byte_sent", 8'(cnt), 8'h00);
      bus_read("status_drained", c_st, 8'h00);

      // Reset in the middle of DATA bit 3 with two bytes still queued
      bus_write(c_ctrl, 8'h00);
      bus_write(c_tx, 8'h37);
      bus_write(c_tx, 8'h11);
      bus_write(c_tx, 8'h22);
      bus_write(c_ctrl, 8'h01);
      @(negedge clk);
      chk("rst_frame_start", {7'b0, uart_tx}, 8'h00);
      repeat (17) @(negedge clk);
      chk("rst_frame_bit3", {7'b0, uart_tx}, 8'h00);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_abort_tx", {7'b0, uart_tx}, 8'h01);
      rst = 1'b0;
      bus_read("rst_abort_status", c_st, 8'h00);
      bus_read("rst_abort_ctrl", c_ctrl, 8'h00);
      bus_write(c_ctrl, 8'h01);
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) cnt++;
      end
      chk("rst_fifo_discarded", 8'(cnt), 8'h00);
      bus_read("rst_status_final", c_st, 8'h00);

      // Interrupt on end of the last frame
      bus_write(c_tx, 8'h3C);
      check_frame("frame_3C", 8'h3C, 1);
      chk("irq_low_during_frame", {7'b0, irq_raise}, 8'h00);
`ifdef UART_TX_IRQ_EN
      @(negedge clk);
      chk("irq_raise", {7'b0, irq_raise}, 8'h01);
      cnt = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (irq_raise === 1'b1) cnt++;
      end
      chk("irq_hold", 8'(cnt), 8'd9);
      irq_ack = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0;
      chk("irq_ack_clear", {7'b0, irq_raise}, 8'h00);
`else
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         irq_ack = (i == 6);
         if (irq_raise !== 1'b0) cnt++;
      end
      irq_ack = 1'b0;
      chk("irq_tied_low", 8'(cnt), 8'h00);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
